// File: rtl/afifo_pkg.sv
// rtl/afifo_pkg.sv - shared types and sizes for the async FIFO read-side drain
package afifo_pkg;

    localparam int DSIZE_DEFAULT = 8;
    localparam int CNT_W_DEFAULT = 16;
    localparam int BUF_DEPTH     = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } drain_state_t;

endpackage

// File: rtl/afifo_skid_buf.sv
// rtl/afifo_skid_buf.sv - 2-entry order-preserving output buffer with synchronous clear
module afifo_skid_buf
    import afifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [DSIZE-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             clr_i,
    output logic [1:0]       count_o,
    output logic [DSIZE-1:0] head_o,
    output logic             valid_o
);

    logic [DSIZE-1:0] mem_q [BUF_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    // Clear wins over a same-edge push or pop; the caller guards push against a full buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clr_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/afifo_rd_drain.sv
// rtl/afifo_rd_drain.sv - read-domain FIFO consumer: pops into a 2-entry buffer, flush/enable FSM, counters
module afifo_rd_drain
    import afifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic [DSIZE-1:0] rd_data,
    input  logic             rd_empty,
    output logic             rd_inc,
    input  logic             en,
    input  logic             flush,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             flushing,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    drain_state_t     state_q;
    logic             flushing_q;
    logic [CNT_W-1:0] beat_q;
    logic [CNT_W-1:0] drop_q;

    logic [1:0]       buf_count;
    logic [DSIZE-1:0] buf_head;
    logic             buf_valid;
    logic             handshake;
    logic             buf_push;
    logic             buf_clr;

    // Pop decision looks only at state, occupancy and empty so m_ready never reaches rd_inc.
    always_comb begin
        rd_inc = 1'b0;
        case (state_q)
            RUN:     rd_inc = !rd_empty && (buf_count < 2'(BUF_DEPTH));
            FLUSH:   rd_inc = !rd_empty;
            default: rd_inc = 1'b0;
        endcase
    end

    assign m_valid   = buf_valid && (state_q != FLUSH);
    assign m_data    = buf_head;
    assign handshake = m_valid && m_ready;
    assign buf_push  = rd_inc && (state_q == RUN);
    assign buf_clr   = flush || (state_q == FLUSH);

    afifo_skid_buf #(
        .DSIZE (DSIZE)
    ) u_buf (
        .clk_i       (rd_clk),
        .rst_i       (rd_rst),
        .push_i      (buf_push),
        .push_data_i (rd_data),
        .pop_i       (handshake),
        .clr_i       (buf_clr),
        .count_o     (buf_count),
        .head_o      (buf_head),
        .valid_o     (buf_valid)
    );

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q    <= IDLE;
            flushing_q <= 1'b0;
        end else if (flush) begin
            state_q    <= FLUSH;
            flushing_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (en) state_q <= RUN;
                RUN:  if (!en) state_q <= IDLE;
                FLUSH: begin
                    if (rd_empty) begin
                        state_q    <= IDLE;
                        flushing_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    flushing_q <= 1'b0;
                end
            endcase
        end
    end

    // Beats wrap; drops stick at all-ones so a long flush cannot alias back to a small count.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            beat_q <= '0;
            drop_q <= '0;
        end else begin
            if (handshake) begin
                beat_q <= beat_q + CNT_W'(1);
            end
            if ((state_q == FLUSH) && rd_inc && (drop_q != '1)) begin
                drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    assign flushing = flushing_q;
    assign beat_cnt = beat_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_afifo_rd_drain.sv
// tb/tb_afifo_rd_drain.sv - scoreboard bench for afifo_rd_drain with a queue-modelled FIFO
module tb_afifo_rd_drain;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic [7:0]  rd_data;
    logic        rd_empty;
    logic        rd_inc;
    logic        en;
    logic        flush;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        flushing;
    logic [15:0] beat_cnt;
    logic [15:0] drop_cnt;

    logic        s_rst = 1'b1;
    logic [7:0]  s_rd_data;
    logic        s_rd_empty;
    logic        s_rd_inc;
    logic        s_en;
    logic        s_flush;
    logic [7:0]  s_m_data;
    logic        s_m_valid;
    logic        s_m_ready;
    logic        s_flushing;
    logic [3:0]  s_beat;
    logic [3:0]  s_drop;

    int          errors = 0;
    int          checks = 0;
    int          pops   = 0;
    logic [7:0]  fifo_q [$];
    logic [7:0]  exp_q  [$];

    afifo_rd_drain #(.DSIZE(8), .CNT_W(16)) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_data(rd_data), .rd_empty(rd_empty),
        .rd_inc(rd_inc), .en(en), .flush(flush), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .flushing(flushing), .beat_cnt(beat_cnt), .drop_cnt(drop_cnt)
    );

    afifo_rd_drain #(.DSIZE(8), .CNT_W(4)) dut_small (
        .rd_clk(rd_clk), .rd_rst(s_rst), .rd_data(s_rd_data), .rd_empty(s_rd_empty),
        .rd_inc(s_rd_inc), .en(s_en), .flush(s_flush), .m_data(s_m_data), .m_valid(s_m_valid),
        .m_ready(s_m_ready), .flushing(s_flushing), .beat_cnt(s_beat), .drop_cnt(s_drop)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        rd_empty = (fifo_q.size() == 0);
        rd_data  = rd_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic load(input logic [7:0] w, input bit expect_out);
        fifo_q.push_back(w);
        if (expect_out) exp_q.push_back(w);
        refresh();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rd_clk);
        #2;
    endtask

    // FIFO model: pop decision sampled mid-cycle, applied just after the edge
    initial begin
        bit pend;
        logic [7:0] tmp;
        refresh();
        forever begin
            @(negedge rd_clk);
            pend = rd_inc;
            if (rd_inc && rd_empty) begin
                errors++;
                $display("FAIL pop_while_empty: rd_inc=1 rd_empty=1 at %0t", $time);
            end
            @(posedge rd_clk);
            #1;
            if (pend && fifo_q.size() > 0) begin
                tmp = fifo_q.pop_front();
                pops++;
            end
            refresh();
        end
    end

    // Scoreboard monitor: every completed handshake must match the next expected word
    initial begin
        forever begin
            @(negedge rd_clk);
            if (!rd_rst && m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", m_data);
                end else begin
                    check("beat_data", m_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int guard;
        en = 0; flush = 0; m_ready = 0;
        s_en = 0; s_flush = 0; s_m_ready = 0; s_rd_data = 8'h5A; s_rd_empty = 1'b0;
        tick(2);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_rd_inc", rd_inc, 0);
        check("rst_flushing", flushing, 0);
        check("rst_beat", beat_cnt, 0);
        check("rst_drop", drop_cnt, 0);
        rd_rst = 0; s_rst = 0;
        tick(1);

        // basic stream
        load(8'h11, 1); load(8'h22, 1); load(8'h33, 1);
        m_ready = 1; en = 1;
        tick(1);
        check("first_pop", rd_inc, 1);
        check("no_valid_before_pop", m_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("stream_valid", m_valid, 1);
        end
        check("stop_on_empty", rd_inc, 0);
        tick(1);
        check("stream_done_valid", m_valid, 0);
        check("basic_beats", beat_cnt, 3);

        // backpressure
        m_ready = 0; pops = 0;
        for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i), 1);
        tick(6);
        check("bp_pops", pops, 2);
        check("bp_hold_data", m_data, 8'hA0);
        check("bp_valid", m_valid, 1);
        check("bp_no_pop_full", rd_inc, 0);
        m_ready = 1;
        tick(10);
        check("bp_beats", beat_cnt, 8);
        check("bp_all_out", exp_q.size(), 0);

        // flush
        m_ready = 0; pops = 0;
        for (int i = 0; i < 6; i++) load(8'hC0 + 8'(i), 0);
        tick(4);
        check("fl_buffered", pops, 2);
        flush = 1; en = 0;
        tick(1);
        ok = 1; guard = 0;
        while (!rd_empty && guard < 20) begin
            if (m_valid || !flushing) ok = 0;
            tick(1);
            guard++;
        end
        check("fl_drain_state", ok, 1);
        check("fl_fifo_empty", rd_empty, 1);
        check("fl_drop", drop_cnt, 4);
        flush = 0;
        tick(1);
        check("fl_exit", flushing, 0);
        check("fl_no_valid", m_valid, 0);
        load(8'hD0, 1);
        m_ready = 1; en = 1;
        tick(4);
        check("fl_resume_beats", beat_cnt, 9);

        // enable gating
        en = 0;
        tick(1);
        pops = 0;
        load(8'hE0, 1); load(8'hE1, 1); load(8'hE2, 0);
        tick(4);
        check("en_gate_pops", pops, 0);
        check("en_gate_valid", m_valid, 0);
        en = 1;
        tick(2);
        en = 0;
        tick(4);
        check("en_mid_pops", pops, 2);
        check("en_mid_left", fifo_q.size(), 1);
        check("en_mid_valid", m_valid, 0);
        check("en_mid_beats", beat_cnt, 11);

        // async reset with a full buffer
        m_ready = 0;
        load(8'hF0, 0); load(8'hF1, 0);
        en = 1;
        tick(4);
        check("pre_rst_valid", m_valid, 1);
        #1 rd_rst = 1;
        #1;
        check("arst_m_valid", m_valid, 0);
        check("arst_rd_inc", rd_inc, 0);
        check("arst_beat", beat_cnt, 0);
        check("arst_drop", drop_cnt, 0);
        check("arst_flushing", flushing, 0);
        en = 0;
        tick(1);
        rd_rst = 0;
        #1;
        check("post_rst_idle", rd_inc, 0);
        tick(2);
        check("post_rst_idle2", rd_inc, 0);
        check("post_rst_valid", m_valid, 0);
        check("sb_empty", exp_q.size(), 0);

        // 4-bit counters: 17 beats wrap to 1, long flush saturates drops
        for (int i = 0; i < 8; i++) begin
            s_en = 1; s_m_ready = 0; tick(3);
            s_en = 0; s_m_ready = 1; tick(3);
            s_m_ready = 0;
        end
        check("s_beat_wrap0", s_beat, 0);
        s_en = 1; tick(3);
        s_en = 0; tick(1);
        s_m_ready = 1; tick(1);
        s_m_ready = 0;
        check("s_beat_wrap1", s_beat, 1);
        s_flush = 1;
        tick(10);
        check("s_drop_9", s_drop, 9);
        check("s_flush_valid", s_m_valid, 0);
        check("s_flushing", s_flushing, 1);
        tick(20);
        check("s_drop_sat", s_drop, 4'hF);
        check("s_beat_kept", s_beat, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
